keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad by driving one column low at a time and sampling the rows. It synchronizes and debounces the rows and decodes each accepted press into a 4-bit hex code. It keeps the two most recent digits (digit_new, digit_old), which feed the dual seven-segment driver's sA/sB inputs directly. One press produces exactly one strobe, however long the key is held.

Parameters:
SCAN_DIV, 12000, clk cycles per scan tick (48 MHz -> 4 kHz tick)
DEBOUNCE_TICKS, 80, consecutive stable ticks needed to accept a press or a release (20 ms at 4 kHz)

Ports:
clk  input  1  system clock, 48 MHz
reset  input  1  asynchronous reset, active-low (asserted at 0)
rows  input  4  keypad rows, active-low, external pull-ups, asynchronous to clk
cols  output  4  keypad columns, active-low, one-hot-low
digit_new  output  4  most recently accepted key code
digit_old  output  4  previously accepted key code
key_strobe  output  1  one-clk pulse when a press is accepted

Behaviour:
- Reset values (applied immediately on reset=0, asynchronously): cols=4'b1110, digit_new=0, digit_old=0, key_strobe=0, state=SCAN, tick and debounce counters=0, synchronizer flops=4'b1111.
- Tick generator: counter runs 0..SCAN_DIV-1; tick is high for one clk when the counter wraps. Counter width is $clog2(SCAN_DIV).
- rows pass through a 2-flop synchronizer. All decisions use the synchronized rows (rs), sampled only on tick.
- Columns change only on tick, so rows get one full tick period to settle before they are sampled.
- Keymap, rows 0..3 by cols 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- SCAN:
  - On tick with rs=4'b1111: rotate the low column (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - On tick with any rs bit low: latch the column index and the lowest-index low row. Hold cols, clear the debounce count, go to DB_PRESS.
- DB_PRESS (cols held):
  - On tick with the latched row low: count++.
  - When the count reaches DEBOUNCE_TICKS-1 on a tick: go to HELD. In the next clk, key_strobe=1, digit_old<=digit_new, digit_new<=code.
  - On tick with the latched row high: go to SCAN and advance the column. No strobe.
- HELD (cols held): other rows are ignored (no multi-key support). On tick with the latched row high: go to DB_RELEASE with count=0.
- DB_RELEASE (cols held):
  - On tick with the latched row high: count++.
  - At DEBOUNCE_TICKS-1: go to SCAN and advance the column.
  - On tick with the latched row low: go back to HELD, clear count, no strobe.
- key_strobe is a registered output, high for exactly one clk per accepted press. Digit registers change only in the cycle key_strobe is high.
- Press latency: the strobe comes DEBOUNCE_TICKS ticks after the detecting tick, plus one clk. Add up to 2 clk of synchronizer delay before detection.
- Debounce counter width is $clog2(DEBOUNCE_TICKS+1). It saturates and never wraps.
- Reset released mid-operation: the block starts fresh in SCAN. A key already held must pass a full DB_PRESS before it is accepted.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DB_PRESS, HELD, DB_RELEASE}
  - NUM_ROWS=4, NUM_COLS=4
  - keymap constant (16x4-bit) plus a decode function (row, col) -> code
- One sub-module, scan_tick_gen: parameterised SCAN_DIV divider with the same clk and reset, producing a single-cycle tick.

Test Plan:
(Simulation overrides: SCAN_DIV=4, DEBOUNCE_TICKS=3.)
1. Reset, then rows=1111 for 40 clk -> cols cycle 1110, 1101, 1011, 0111, 1110 with each step lasting 4 clk. key_strobe stays 0 and both digits stay 0.
2. Model key '5' (rows[1] low while cols[1] low), held for 30 ticks -> exactly one key_strobe, digit_new=5, digit_old=0. cols stay frozen at 1101 while the key is held.
3. Release '5' cleanly, then press 'A' (row 0, col 3) -> digit_new=A, digit_old=5, one strobe.
4. Bounce: rows[2] low for 1 tick during col 0, then high -> no strobe, digits unchanged, scanning resumes at col 1.
5. Hold '0' (row 3, col 1) and during DB_RELEASE toggle the row low for 1 tick -> block returns to HELD. After the final clean release, the total strobe count is 1.
6. Assert reset=0 asynchronously mid-DB_PRESS -> outputs take reset values in the same cycle. Release reset with the key still held -> strobe appears only after a full DEBOUNCE_TICKS debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Purpose : shared types, sizes and key decode for the 4x4 keypad scanner.
// Latency : n/a (declarations and a pure combinational helper only).
// Backpr. : n/a.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Nibble index = {row, col}; nibble 0 (row 0, col 0) sits in the LSBs.
    //   row 0: 1 2 3 A   row 1: 4 5 6 B   row 2: 7 8 9 C   row 3: E 0 F D
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        idx = {row, col};
        return KEYMAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Purpose : free-running divider producing a one-clk scan tick every SCAN_DIV clks.
// Latency : tick is combinational from the counter; first tick SCAN_DIV clks after reset.
// Backpr. : none, free-running.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous reset, active-low
//   tick_o - high for one clk when the counter wraps
module scan_tick_gen #(
    parameter int SCAN_DIV = 12000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == CNT_MAX);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low keypad, debounces and decodes presses into hex digits.
// Latency : strobe DEBOUNCE_TICKS ticks after the detecting tick plus one clk (+2 clk sync).
// Backpr. : none; one strobe per accepted press, key_strobe is never held off.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous reset, active-low
//   rows       - keypad rows, active-low, asynchronous to clk
//   cols       - keypad columns, one-hot-low drive
//   digit_new  - most recently accepted key code
//   digit_old  - previously accepted key code
//   key_strobe - one-clk pulse when a press is accepted
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_TICKS = 80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic [3:0]          digit_new,
    output logic [3:0]          digit_old,
    output logic                key_strobe
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] CNT_SAT  = DW'(DEBOUNCE_TICKS);

    logic tick;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    // Two-flop synchronizer; resets to "no key" so nothing is seen during reset.
    logic [NUM_ROWS-1:0] sync1_q;
    logic [NUM_ROWS-1:0] rs_q;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;
    logic [3:0]    digit_new_q, digit_new_d;
    logic [3:0]    digit_old_q, digit_old_d;

    logic [1:0]    first_row;
    logic          row_low;
    logic [DW-1:0] cnt_inc;

    assign cols       = 4'b1111 ^ (4'b0001 << col_q);
    assign digit_new  = digit_new_q;
    assign digit_old  = digit_old_q;
    assign key_strobe = strobe_q;

    always_comb begin
        // Lowest-index low row wins when several rows are low at detection.
        first_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rs_q[r]) begin
                first_row = 2'(r);
            end
        end
        row_low = ~rs_q[row_q];
        cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        strobe_d    = 1'b0;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&rs_q) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d   = first_row;
                        cnt_d   = '0;
                        state_d = DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (row_low) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d     = HELD;
                            strobe_d    = 1'b1;
                            digit_old_d = digit_new_q;
                            digit_new_d = decode_key(row_q, col_q);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: abandon this column and keep scanning.
                        state_d = SCAN;
                        col_d   = col_q + 1'b1;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other keys are ignored.
                    if (!row_low) begin
                        state_d = DB_RELEASE;
                        cnt_d   = '0;
                    end
                end
                DB_RELEASE: begin
                    if (!row_low) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = SCAN;
                            col_d   = col_q + 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Release bounced: still held, no second strobe.
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '1;
            rs_q        <= '1;
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            sync1_q     <= rows;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DT = 3;
    // Key pressed right after its column goes low: detected on the next tick,
    // then DT more ticks of debounce; strobe follows that tick edge.
    localparam int PRESS_LAT = SD * (DT + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_strobe;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;

    // Physical keypad model: one key at (key_r, key_c) shorts its row to its column.
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_rows = 4'hF;

    // Reference keymap, index = row*4 + col.
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    logic [3:0] exp_new = 4'h0;
    logic [3:0] exp_old = 4'h0;
    int         exp_strobes = 0;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rows       (rows),
        .cols       (cols),
        .digit_new  (digit_new),
        .digit_old  (digit_old),
        .key_strobe (key_strobe)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        if (ovr_en) begin
            rows = ovr_rows;
        end else if (key_down && cols[key_c] == 1'b0) begin
            rows[key_r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Strobe counter and digit-stability monitor.
    logic [3:0] prev_new = 4'h0;
    logic [3:0] prev_old = 4'h0;
    logic       prev_rst = 1'b0;
    always @(negedge clk) begin
        if (key_strobe === 1'b1) strobe_cnt++;
        if (reset && prev_rst && (digit_new !== prev_new || digit_old !== prev_old))
            check("digit_change_without_strobe", {31'd0, key_strobe}, 32'd1);
        prev_new = digit_new;
        prev_old = digit_old;
        prev_rst = reset;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] r, input logic [1:0] c);
        exp_old = exp_new;
        exp_new = kmap[{r, c}];
        exp_strobes++;
    endtask

    // Waits until scanning moves onto column c (just after that tick edge).
    task automatic align_to_col(input logic [1:0] c);
        logic [3:0] tgt;
        logic [3:0] prev;
        logic       ok;
        tgt  = 4'hF ^ (4'h1 << c);
        prev = cols;
        ok   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (cols === tgt && prev !== tgt) begin
                ok = 1'b1;
                break;
            end
            prev = cols;
        end
        check("align_to_col", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_strobe(input int limit, output int edges, output logic seen);
        edges = 0;
        seen  = 1'b0;
        while (edges < limit && !seen) begin
            step(1);
            edges++;
            if (key_strobe === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_digits(input string tag);
        check({tag, "_new"}, {28'd0, digit_new}, {28'd0, exp_new});
        check({tag, "_old"}, {28'd0, digit_old}, {28'd0, exp_old});
    endtask

    task automatic press_release(input logic [1:0] r, input logic [1:0] c,
                                 input int hold_ticks, input string tag);
        int   e;
        logic s;
        align_to_col(c);
        key_r = r;
        key_c = c;
        key_down = 1'b1;
        wait_strobe(64, e, s);
        check({tag, "_strobe_seen"}, {31'd0, s}, 32'd1);
        check({tag, "_latency"}, e, PRESS_LAT);
        accept(r, c);
        check_digits(tag);
        step(hold_ticks * SD);
        check({tag, "_cols_frozen"}, {28'd0, cols}, {28'd0, 4'hF ^ (4'h1 << c)});
        check({tag, "_one_strobe_held"}, strobe_cnt, exp_strobes);
        key_down = 1'b0;
        step((DT + 3) * SD);
        check({tag, "_one_strobe_released"}, strobe_cnt, exp_strobes);
    endtask

    initial begin
        int         e;
        logic       s;
        logic [1:0] rr;
        logic [1:0] cc;
        logic [1:0] idx;

        // Reset state.
        step(3);
        check("rst_cols", {28'd0, cols}, 32'hE);
        check("rst_strobe", {31'd0, key_strobe}, 32'd0);
        check_digits("rst");

        // Idle scanning: column index advances once every SD clocks.
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            idx = 2'((k / SD) % 4);
            check("idle_cols", {28'd0, cols}, {28'd0, 4'hF ^ (4'h1 << idx)});
        end
        check("idle_no_strobe", strobe_cnt, 0);
        check_digits("idle");

        // Key '5' held for 30 ticks, then 'A'.
        press_release(2'd1, 2'd1, 30, "key5");
        press_release(2'd0, 2'd3, 5, "keyA");

        // One-tick bounce on row 2 during column 0.
        align_to_col(2'd0);
        ovr_rows = 4'b1011;
        ovr_en   = 1'b1;
        step(SD);
        check("bounce_cols_held", {28'd0, cols}, 32'hE);
        ovr_rows = 4'hF;
        step(SD);
        check("bounce_resume_col1", {28'd0, cols}, 32'hD);
        ovr_en = 1'b0;
        check("bounce_no_strobe", strobe_cnt, exp_strobes);
        check_digits("bounce");

        // Key '0' with a low glitch during release debounce.
        align_to_col(2'd1);
        key_r = 2'd3;
        key_c = 2'd1;
        key_down = 1'b1;
        wait_strobe(64, e, s);
        check("key0_strobe_seen", {31'd0, s}, 32'd1);
        check("key0_latency", e, PRESS_LAT);
        accept(2'd3, 2'd1);
        check_digits("key0");
        key_down = 1'b0;
        step(2 * SD);
        key_down = 1'b1;
        step(SD);
        key_down = 1'b0;
        step(3 * SD + 1);
        check("glitch_back_to_held", {28'd0, cols}, 32'hD);
        step(SD);
        check("release_after_glitch", {28'd0, cols}, 32'hB);
        check("glitch_single_strobe", strobe_cnt, exp_strobes);

        // Random keys.
        for (int i = 0; i < 6; i++) begin
            rr = 2'($urandom_range(3, 0));
            cc = 2'($urandom_range(3, 0));
            press_release(rr, cc, int'($urandom_range(12, 2)), "rand");
        end

        // Asynchronous reset in the middle of press debounce, key kept held.
        rr = 2'($urandom_range(3, 0));
        cc = 2'($urandom_range(3, 0));
        align_to_col(cc);
        key_r = rr;
        key_c = cc;
        key_down = 1'b1;
        step(2 * SD);
        check("midpress_no_strobe_yet", strobe_cnt, exp_strobes);
        #1 reset = 1'b0;
        #1;
        exp_new = 4'h0;
        exp_old = 4'h0;
        check("async_rst_cols", {28'd0, cols}, 32'hE);
        check("async_rst_strobe", {31'd0, key_strobe}, 32'd0);
        check_digits("async_rst");
        step(2);
        reset = 1'b1;
        wait_strobe(64, e, s);
        check("post_rst_strobe_seen", {31'd0, s}, 32'd1);
        check("post_rst_latency", e, SD * (int'(cc) + 1 + DT));
        accept(rr, cc);
        check_digits("post_rst");
        key_down = 1'b0;
        step((DT + 3) * SD);
        check("post_rst_strobe_count", strobe_cnt, exp_strobes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
